// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch control slice.
// FSM state encoding and the per-anode blank patterns used in adjust mode.
package sw_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    ADJ   = 2'd2
  } sw_state_e;

  localparam logic [3:0] MASK_MIN = 4'b1100;
  localparam logic [3:0] MASK_SEC = 4'b0011;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-sample counter; the output level
// follows the synchronized input once it has differed for DEB_CYCLES cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic btnR,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // Any sample that agrees with the current level restarts the run.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge btnR) begin
    if (btnR) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons, 1 Hz / 2 Hz divider and a RUN/PAUSE/ADJ
// FSM producing registered increment strobes and the adjust-mode blink mask.
module stopwatch_ctrl
  import sw_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       btnR,
  input  logic       btnMid,
  input  logic       btn2,
  input  logic       btnS,
  output logic       inc_sec,
  output logic       inc_min,
  output logic [3:0] blank_mask,
  output logic       paused,
  output logic       adj
);

  localparam int unsigned DW = $clog2(CLK_HZ);
  localparam logic [DW-1:0] DIV_LAST      = DW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DIV_HALF      = DW'(CLK_HZ / 2);
  localparam logic [DW-1:0] DIV_HALF_LAST = DW'(CLK_HZ / 2 - 1);

  logic mid_lvl, adj_lvl, sel_lvl;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mid (
    .clk(clk), .btnR(btnR), .raw(btnMid), .level(mid_lvl)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj (
    .clk(clk), .btnR(btnR), .raw(btn2), .level(adj_lvl)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .btnR(btnR), .raw(btnS), .level(sel_lvl)
  );

  logic          mid_prev_q, press_q, press_d;
  logic [DW-1:0] div_q, div_d;
  sw_state_e     state_q, state_d;
  logic          saved_pause_q, saved_pause_d;
  logic          inc_sec_q, inc_sec_d;
  logic          inc_min_q, inc_min_d;
  logic [3:0]    blank_q, blank_d;
  logic          tick1, tick2, blink_off;

  always_comb begin
    press_d   = mid_lvl & ~mid_prev_q;
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick1     = (div_q == DIV_LAST);
    tick2     = (div_q == DIV_HALF_LAST) | tick1;
    blink_off = (div_q >= DIV_HALF);

    state_d       = state_q;
    saved_pause_d = saved_pause_q;
    // Entering ADJ wins over a same-cycle pause press, which is dropped.
    case (state_q)
      RUN: begin
        if (adj_lvl) begin
          state_d = ADJ;
        end else if (press_q) begin
          state_d       = PAUSE;
          saved_pause_d = 1'b1;
        end
      end
      PAUSE: begin
        if (adj_lvl) begin
          state_d = ADJ;
        end else if (press_q) begin
          state_d       = RUN;
          saved_pause_d = 1'b0;
        end
      end
      ADJ: begin
        if (!adj_lvl) state_d = saved_pause_q ? PAUSE : RUN;
      end
      default: state_d = RUN;
    endcase

    inc_sec_d = ((state_q == RUN) & tick1) | ((state_q == ADJ) & tick2 & sel_lvl);
    inc_min_d = (state_q == ADJ) & tick2 & ~sel_lvl;
    blank_d   = '0;
    if ((state_q == ADJ) && blink_off) blank_d = sel_lvl ? MASK_SEC : MASK_MIN;
  end

  always_ff @(posedge clk or posedge btnR) begin
    if (btnR) begin
      mid_prev_q    <= 1'b0;
      press_q       <= 1'b0;
      div_q         <= '0;
      state_q       <= RUN;
      saved_pause_q <= 1'b0;
      inc_sec_q     <= 1'b0;
      inc_min_q     <= 1'b0;
      blank_q       <= '0;
    end else begin
      mid_prev_q    <= mid_lvl;
      press_q       <= press_d;
      div_q         <= div_d;
      state_q       <= state_d;
      saved_pause_q <= saved_pause_d;
      inc_sec_q     <= inc_sec_d;
      inc_min_q     <= inc_min_d;
      blank_q       <= blank_d;
    end
  end

  assign inc_sec    = inc_sec_q;
  assign inc_min    = inc_min_q;
  assign blank_mask = blank_q;
  assign paused     = (state_q == PAUSE);
  assign adj        = (state_q == ADJ);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a cycle-level reference model pushes the
// expected outputs per clock; a monitor pops and compares on the falling edge.
module tb_stopwatch_ctrl;

  localparam int unsigned HZ  = 8;
  localparam int unsigned DEB = 3;

  logic       clk = 1'b0;
  logic       btnR, btnMid, btn2, btnS;
  logic       inc_sec, inc_min, paused, adj;
  logic [3:0] blank_mask;

  stopwatch_ctrl #(.CLK_HZ(HZ), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .btnR(btnR), .btnMid(btnMid), .btn2(btn2), .btnS(btnS),
    .inc_sec(inc_sec), .inc_min(inc_min), .blank_mask(blank_mask),
    .paused(paused), .adj(adj)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       m;
    logic [3:0] bm;
    logic       p;
    logic       a;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=run 1=pause 2=adj; button index 0=mid 1=adj 2=sel.
  int          m_mode;
  bit          m_saved;
  int          m_div;
  bit          m_lvl[3];
  logic [15:0] m_hist[3];
  bit          m_rose1, m_rose2;

  function automatic void model_reset();
    m_mode = 0; m_saved = 0; m_div = 0;
    m_rose1 = 0; m_rose2 = 0;
    for (int b = 0; b < 3; b++) begin
      m_lvl[b]  = 0;
      m_hist[b] = '0;
    end
  endfunction

  function automatic exp_t model_step(input bit r0, input bit r1, input bit r2);
    exp_t e;
    bit   raw[3];
    bit   t1, t2, blink, sel, adjl, evt, old_mid, flip;
    raw[0] = r0; raw[1] = r1; raw[2] = r2;
    t1    = (m_div == HZ - 1);
    t2    = ((m_div % (HZ / 2)) == HZ / 2 - 1);
    blink = (m_div >= HZ / 2);
    sel   = m_lvl[2];
    adjl  = m_lvl[1];
    e.s  = (m_mode == 0 && t1) || (m_mode == 2 && t2 && sel);
    e.m  = (m_mode == 2 && t2 && !sel);
    e.bm = (m_mode == 2 && blink) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
    evt  = m_rose2;
    if (m_mode == 0) begin
      if (adjl) m_mode = 2;
      else if (evt) begin m_mode = 1; m_saved = 1; end
    end else if (m_mode == 1) begin
      if (adjl) m_mode = 2;
      else if (evt) begin m_mode = 0; m_saved = 0; end
    end else begin
      if (!adjl) m_mode = m_saved ? 1 : 0;
    end
    e.p = (m_mode == 1);
    e.a = (m_mode == 2);
    m_div = (m_div + 1) % HZ;
    old_mid = m_lvl[0];
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][14:0], raw[b]};
      // Level flips when the samples two edges old and the DEB-1 before all disagree.
      flip = 1;
      for (int j = 2; j < 2 + DEB; j++) if (m_hist[b][j] == m_lvl[b]) flip = 0;
      if (flip) m_lvl[b] = !m_lvl[b];
    end
    m_rose2 = m_rose1;
    m_rose1 = !old_mid && m_lvl[0];
    return e;
  endfunction

  initial begin
    exp_t z;
    z.s = 0; z.m = 0; z.bm = '0; z.p = 0; z.a = 0;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (btnR) begin
        model_reset();
        expq.push_back(z);
      end else begin
        expq.push_back(model_step(btnMid, btn2, btnS));
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("inc_sec",    4'(inc_sec), 4'(e.s));
        chk("inc_min",    4'(inc_min), 4'(e.m));
        chk("blank_mask", blank_mask,  e.bm);
        chk("paused",     4'(paused),  4'(e.p));
        chk("adj",        4'(adj),     4'(e.a));
        chk("strobe_excl", 4'(inc_sec & inc_min), 4'd0);
      end
    end
  end

  // Inputs change 7 time units after each rising edge, clear of sampling points.
  task automatic wait_cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #7;
    end
  endtask

  task automatic set_in(input logic mid, input logic b2, input logic s, input int unsigned n);
    btnMid = mid; btn2 = b2; btnS = s;
    wait_cyc(n);
  endtask

  task automatic pulse_reset(input int unsigned n);
    btnR = 1'b1;
    #1;
    chk("rst_inc_sec", 4'(inc_sec), 4'd0);
    chk("rst_inc_min", 4'(inc_min), 4'd0);
    chk("rst_blank",   blank_mask,  4'd0);
    chk("rst_paused",  4'(paused),  4'd0);
    chk("rst_adj",     4'(adj),     4'd0);
    wait_cyc(n);
    btnR = 1'b0;
  endtask

  initial begin
    btnR = 1'b1; btnMid = 1'b0; btn2 = 1'b0; btnS = 1'b0;
    wait_cyc(3);
    btnR = 1'b0;
    set_in(0, 0, 0, 30);
    // pause and resume with long presses
    set_in(1, 0, 0, 10);
    set_in(0, 0, 0, 20);
    set_in(1, 0, 0, 10);
    set_in(0, 0, 0, 20);
    // short glitch
    set_in(1, 0, 0, 2);
    set_in(0, 0, 0, 15);
    // adjust minutes, then seconds, then leave
    set_in(0, 1, 0, 30);
    set_in(0, 1, 1, 30);
    set_in(0, 0, 0, 20);
    // pause, adjust, return to pause
    set_in(1, 0, 0, 10);
    set_in(0, 0, 0, 10);
    set_in(0, 1, 0, 20);
    set_in(0, 0, 0, 30);
    // reset mid-adjust
    set_in(0, 1, 1, 20);
    pulse_reset(2);
    set_in(0, 0, 0, 30);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 24) == 0) pulse_reset($urandom_range(1, 3));
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), $urandom_range(1, 10));
    end
    set_in(0, 0, 0, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, clk cycles per second; SHALL be even and >= 4.
REQ-002 Parameter DEB_CYCLES, default 1_000_000, consecutive stable synchronized samples needed to accept a button level change.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 btnR  input  1  reset, asynchronous, active-high.
REQ-005 btnMid  input  1  raw pause pushbutton; each debounced press toggles run/pause.
REQ-006 btn2  input  1  raw ADJ switch; debounced level 1 selects adjust mode.
REQ-007 btnS  input  1  raw SEL switch; debounced 0 = minutes, 1 = seconds.
REQ-008 inc_sec  output  1  one-cycle strobe: seconds counter +1; datapath handles carry.
REQ-009 inc_min  output  1  one-cycle strobe: minutes counter +1 (adjust only; no carry into seconds).
REQ-010 blank_mask  output  4  per-anode blank request to the display scanner; bit3..0 = an[3]..an[0].
REQ-011 paused  output  1  1 when the FSM is in PAUSE.
REQ-012 adj  output  1  1 when the FSM is in ADJ.

Function
REQ-013 Three identical debouncers on btnMid, btn2 and btnS: 2-flop synchronizer, then a stable counter; the debounced level SHALL change exactly when the synchronized input has differed from it for DEB_CYCLES consecutive cycles. Total raw-to-level latency: 2+DEB_CYCLES cycles.
REQ-014 Glitches shorter than DEB_CYCLES cycles SHALL NOT change the debounced level.
REQ-015 Pause press event = one-cycle pulse on the cycle after the debounced btnMid rises 0->1.
REQ-016 Free-running divider div_cnt counts 0..CLK_HZ-1 and wraps to 0; only reset clears it; mode changes SHALL NOT clear it.
REQ-017 tick1 = (div_cnt == CLK_HZ-1); tick2 = (div_cnt == CLK_HZ/2-1) or tick1; blink_off = (div_cnt >= CLK_HZ/2).
REQ-018 FSM states RUN, PAUSE, ADJ; a saved_pause flag records the RUN/PAUSE choice.
REQ-019 RUN -> PAUSE on pause event; PAUSE -> RUN on pause event.
REQ-020 RUN or PAUSE -> ADJ when debounced btn2 = 1 (priority over a same-cycle pause event, which is discarded).
REQ-021 ADJ -> PAUSE when debounced btn2 = 0 and saved_pause = 1, else ADJ -> RUN; pause events in ADJ are ignored.
REQ-022 inc_sec = (RUN & tick1) | (ADJ & tick2 & sel); inc_min = ADJ & tick2 & ~sel; both are registered, one cycle after the tick.
REQ-023 inc_sec and inc_min SHALL never be 1 in the same cycle; PAUSE emits no strobes.
REQ-024 blank_mask = 4'b1100 in ADJ with sel = 0 and blink_off; 4'b0011 in ADJ with sel = 1 and blink_off; 4'b0000 otherwise; registered.
REQ-025 A sel change in ADJ takes effect on the next tick2 and the next blank_mask update, with no extra strobe.

Reset
REQ-026 While btnR = 1: state RUN, saved_pause 0, div_cnt 0, all debouncer levels and counters 0, inc_sec 0, inc_min 0, blank_mask 0, paused 0, adj 0, asynchronously, including mid-debounce and mid-ADJ.
REQ-027 After btnR falls, the first inc_sec SHALL be asserted CLK_HZ cycles later (div_cnt reaches CLK_HZ-1 and the strobe is registered).

Structure
REQ-028 Shared package sw_pkg: the FSM state enum (RUN, PAUSE, ADJ) and the blank-mask constants MASK_MIN = 4'b1100 and MASK_SEC = 4'b0011.
REQ-029 One sub-module btn_debounce (parameter DEB_CYCLES; ports clk, btnR, raw, level), instantiated three times; the divider and FSM are inline.

Verification (CLK_HZ = 8, DEB_CYCLES = 3)
REQ-030 Release reset with no buttons pressed -> inc_sec pulses at cycles 8, 16 and 24 after release; inc_min, paused, adj and blank_mask stay 0.
REQ-031 btnMid held high for 10 cycles -> paused = 1 within 7 cycles and inc_sec stops; a second 10-cycle press -> paused = 0 and strobes resume on the next tick1.
REQ-032 btnMid high for 2 cycles only -> no toggle; paused stays 0.
REQ-033 btn2 = 1, btnS = 0 -> adj = 1; inc_min pulses twice per 8 cycles; blank_mask = 1100 for 4 of every 8 cycles. Set btnS = 1 -> inc_sec pulses instead and blank_mask = 0011.
REQ-034 Pause, then btn2 = 1, then btn2 = 0 -> returns to PAUSE (paused = 1, adj = 0), with no strobes after exit.
REQ-035 btnR pulsed high mid-ADJ -> all outputs 0 in the same cycle; behaviour after release matches REQ-030.
